llc_rst_flush_ctrl: RTL and testbench

LLC_RST_FLUSH_CTRL -- requirements
Module: llc_rst_flush_ctrl

---
 rtl/llc_rst_flush_ctrl.sv | 179 +++++++++++++++++
 tb/tb_llc_rst_flush_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_rst_flush_ctrl.sv
// llc_rst_flush_ctrl
// Sweeps every LLC set once, either invalidating it (reset mode) or flushing
// it (flush mode). Each set is read into the way buffers (RD), then the
// update datapath is driven for one cycle (UPD). In flush mode a set holding
// dirty data can be handed to the writeback engine (WB) before moving on.
//
// Build option:
//   LLC_FLUSH_WB_EN  defined   -> WB state and wb_req/wb_ack handshake active
//                    undefined -> WB unreachable, wb_req tied low,
//                                 wb_needed/wb_ack ignored
module llc_rst_flush_ctrl #(
   parameter int SETS     = 256,
   parameter int SET_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_rst,
   input  logic                start_flush,
   input  logic                stall,
   input  logic                wb_needed,
   input  logic                wb_ack,
   output logic                rd_en,
   output logic [SET_BITS-1:0] set,
   output logic                update_en,
   output logic                is_rst_to_resume,
   output logic                is_flush_to_resume,
   output logic                wb_req,
   output logic                busy,
   output logic                done
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_UPD  = 3'd2;
   localparam logic [2:0] ST_WB   = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic MODE_RST   = 1'b0;
   localparam logic MODE_FLUSH = 1'b1;

   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);
   localparam logic [SET_BITS-1:0] SET_ZERO = {SET_BITS{1'b0}};
   localparam logic [SET_BITS-1:0] SET_ONE  = SET_BITS'(1);

   logic [2:0]          state_q, state_d;
   logic [SET_BITS-1:0] set_q, set_d;
   logic                mode_q, mode_d;
   logic                update_en_q, update_en_d;
   logic                is_rst_q, is_rst_d;
   logic                is_flush_q, is_flush_d;
   logic                wb_req_q, wb_req_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Writeback qualifiers: with writeback disabled the WB branch is never
   // taken, and an ack is treated as always present so that a corrupted
   // state register cannot park the sweep in WB.
   logic                wb_take_s;
   logic                wb_ack_s;
`ifdef LLC_FLUSH_WB_EN
   assign wb_take_s = (mode_q == MODE_FLUSH) && wb_needed;
   assign wb_ack_s  = wb_ack;
`else
   logic                unused_wb_s;
   assign unused_wb_s = wb_needed ^ wb_ack;
   assign wb_take_s   = 1'b0;
   assign wb_ack_s    = 1'b1;
`endif

   // Sweep sequencing: next state, set index and sweep mode.
   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: begin
            if (start_rst) begin
               // Reset wins over a simultaneous flush request.
               state_d = ST_RD;
               mode_d  = MODE_RST;
               set_d   = SET_ZERO;
            end else if (start_flush) begin
               state_d = ST_RD;
               mode_d  = MODE_FLUSH;
               set_d   = SET_ZERO;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            if (!stall) begin
               state_d = ST_UPD;
            end else begin
               state_d = ST_RD;
            end
         end
         ST_UPD: begin
            if (wb_take_s) begin
               state_d = ST_WB;
            end else if (set_q == LAST_SET) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RD;
               set_d   = set_q + SET_ONE;
            end
         end
         ST_WB: begin
            if (!wb_ack_s) begin
               state_d = ST_WB;
            end else if (set_q == LAST_SET) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RD;
               set_d   = set_q + SET_ONE;
            end
         end
         ST_DONE: begin
            // Set index stays at the last set; it is only cleared by a start.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            set_d   = SET_ZERO;
            mode_d  = MODE_RST;
         end
      endcase
   end

   // Output decode from the next state so every status output is a flop.
   always_comb begin
      update_en_d = (state_d == ST_UPD);
      is_rst_d    = (state_d == ST_UPD) && (mode_d == MODE_RST);
      is_flush_d  = (state_d == ST_UPD) && (mode_d == MODE_FLUSH);
`ifdef LLC_FLUSH_WB_EN
      wb_req_d    = (state_d == ST_WB);
`else
      wb_req_d    = 1'b0;
`endif
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
   end

   // State and registered outputs; reset abandons any sweep in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         set_q       <= SET_ZERO;
         mode_q      <= MODE_RST;
         update_en_q <= 1'b0;
         is_rst_q    <= 1'b0;
         is_flush_q  <= 1'b0;
         wb_req_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         set_q       <= set_d;
         mode_q      <= mode_d;
         update_en_q <= update_en_d;
         is_rst_q    <= is_rst_d;
         is_flush_q  <= is_flush_d;
         wb_req_q    <= wb_req_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // The read strobe has to follow this cycle's stall, so it is decoded from
   // the state flop rather than registered.
   assign rd_en              = (state_q == ST_RD) && !stall;
   assign set                = set_q;
   assign update_en          = update_en_q;
   assign is_rst_to_resume   = is_rst_q;
   assign is_flush_to_resume = is_flush_q;
   assign wb_req             = wb_req_q;
   assign busy               = busy_q;
   assign done               = done_q;

endmodule

// File: tb/tb_llc_rst_flush_ctrl.sv
// Bench for llc_rst_flush_ctrl with SETS=4. Per-cycle stimulus and expected
// outputs are queued together as each scenario is built, then replayed and
// compared cycle by cycle. Honors LLC_FLUSH_WB_EN for the writeback checks.
module tb_llc_rst_flush_ctrl;

   localparam int SETS     = 4;
   localparam int SET_BITS = 2;
`ifdef LLC_FLUSH_WB_EN
   localparam bit WB_EN = 1'b1;
`else
   localparam bit WB_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                start_rst = 1'b0;
   logic                start_flush = 1'b0;
   logic                stall = 1'b0;
   logic                wb_needed = 1'b0;
   logic                wb_ack = 1'b0;
   logic                rd_en;
   logic [SET_BITS-1:0] set;
   logic                update_en;
   logic                is_rst_to_resume;
   logic                is_flush_to_resume;
   logic                wb_req;
   logic                busy;
   logic                done;

   int total = 0;
   int bad   = 0;

   // stimulus: {start_rst, start_flush, stall, wb_needed, wb_ack}
   logic [4:0] stim_q[$];
   // expected: {busy, done, rd_en, update_en, is_rst, is_flush, wb_req, set}
   logic [8:0] exp_q[$];
   logic [1:0] idle_set = 2'd0;

   llc_rst_flush_ctrl #(.SETS(SETS), .SET_BITS(SET_BITS)) dut (
      .clk(clk), .rst(rst), .start_rst(start_rst), .start_flush(start_flush),
      .stall(stall), .wb_needed(wb_needed), .wb_ack(wb_ack), .rd_en(rd_en),
      .set(set), .update_en(update_en), .is_rst_to_resume(is_rst_to_resume),
      .is_flush_to_resume(is_flush_to_resume), .wb_req(wb_req), .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] mk(input logic b, input logic d, input logic r,
                                     input logic u, input logic ir, input logic fl,
                                     input logic w, input logic [1:0] s);
      return {b, d, r, u, ir, fl, w, s};
   endfunction

   function automatic logic [8:0] obs();
      return {busy, done, rd_en, update_en, is_rst_to_resume,
              is_flush_to_resume, wb_req, set};
   endfunction

   // Queue one complete sweep: start cycle, RD/UPD per set (optional stall
   // and writeback), DONE, then one idle cycle. noise raises both start
   // inputs in cycles where they must be ignored.
   task automatic push_sweep(input logic do_rst, input logic do_flush,
                             input int wb_set, input int stall_set, input int stall_n,
                             input logic wb_all, input logic noise);
      logic mode_rst;
      logic wbn;
      mode_rst = do_rst;
      stim_q.push_back({do_rst, do_flush, 3'b000});
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idle_set));
      for (int s = 0; s < SETS; s++) begin
         if (s == stall_set) begin
            for (int k = 0; k < stall_n; k++) begin
               stim_q.push_back({noise, noise, 3'b100});
               exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(s)));
            end
         end
         stim_q.push_back({noise, noise, 3'b000});
         exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'(s)));
         wbn = wb_all || (s == wb_set);
         stim_q.push_back({2'b00, 1'b0, wbn, wb_all});
         exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, mode_rst, !mode_rst, 1'b0, 2'(s)));
         if (WB_EN && !mode_rst && wbn) begin
            for (int k = 0; k < 3; k++) begin
               stim_q.push_back({noise, noise, 2'b00, (k == 2)});
               exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'(s)));
            end
         end
      end
      stim_q.push_back({noise, noise, 3'b000});
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3));
      stim_q.push_back(5'b00000);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3));
      idle_set = 2'd3;
   endtask

   task automatic test_reset();
      logic [8:0] o;
      int c;
      rst = 1'b0;
      #12;
      o = obs();
      total++;
      if (o !== 9'd0) begin
         bad++;
         $display("FAIL reset_hold got=%b exp=%b", o, 9'd0);
      end
      @(posedge clk); #3;
      rst = 1'b1;
      @(posedge clk); #1;
      idle_set = 2'd0;
      for (int k = 0; k < 4; k++) begin
         stim_q.push_back(5'b00000);
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      end
      c = 0;
      while (stim_q.size() > 0) begin
         {start_rst, start_flush, stall, wb_needed, wb_ack} = stim_q.pop_front();
         @(negedge clk);
         o = obs();
         total++;
         if (o !== exp_q[0]) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, o, exp_q[0]);
         end
         void'(exp_q.pop_front());
         c++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rst_sweep();
      logic [8:0] o;
      int c;
      push_sweep(1'b1, 1'b0, -1, -1, 0, 1'b0, 1'b0);
      c = 0;
      while (stim_q.size() > 0) begin
         {start_rst, start_flush, stall, wb_needed, wb_ack} = stim_q.pop_front();
         @(negedge clk);
         o = obs();
         total++;
         if (o !== exp_q[0]) begin
            bad++;
            $display("FAIL rst_sweep cyc=%0d got=%b exp=%b", c, o, exp_q[0]);
         end
         void'(exp_q.pop_front());
         c++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush_wb();
      logic [8:0] o;
      int c;
      if (WB_EN) push_sweep(1'b0, 1'b1, 2, -1, 0, 1'b0, 1'b0);
      else       push_sweep(1'b0, 1'b1, -1, -1, 0, 1'b1, 1'b0);
      c = 0;
      while (stim_q.size() > 0) begin
         {start_rst, start_flush, stall, wb_needed, wb_ack} = stim_q.pop_front();
         @(negedge clk);
         o = obs();
         total++;
         if (o !== exp_q[0]) begin
            bad++;
            $display("FAIL flush_wb cyc=%0d got=%b exp=%b", c, o, exp_q[0]);
         end
         void'(exp_q.pop_front());
         c++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_both_start();
      logic [8:0] o;
      int c;
      push_sweep(1'b1, 1'b1, -1, -1, 0, 1'b1, 1'b0);
      c = 0;
      while (stim_q.size() > 0) begin
         {start_rst, start_flush, stall, wb_needed, wb_ack} = stim_q.pop_front();
         @(negedge clk);
         o = obs();
         total++;
         if (o !== exp_q[0]) begin
            bad++;
            $display("FAIL both_start cyc=%0d got=%b exp=%b", c, o, exp_q[0]);
         end
         void'(exp_q.pop_front());
         c++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      logic [8:0] o;
      int c;
      push_sweep(1'b0, 1'b1, -1, 1, 5, 1'b0, 1'b0);
      c = 0;
      while (stim_q.size() > 0) begin
         {start_rst, start_flush, stall, wb_needed, wb_ack} = stim_q.pop_front();
         @(negedge clk);
         o = obs();
         total++;
         if (o !== exp_q[0]) begin
            bad++;
            $display("FAIL stall cyc=%0d got=%b exp=%b", c, o, exp_q[0]);
         end
         void'(exp_q.pop_front());
         c++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_async_reset();
      logic [8:0] o;
      int c;
      // Run a reset sweep up to the UPD cycle of set 2 (cycle 6).
      push_sweep(1'b1, 1'b0, -1, -1, 0, 1'b0, 1'b0);
      for (c = 0; c < 7; c++) begin
         {start_rst, start_flush, stall, wb_needed, wb_ack} = stim_q.pop_front();
         @(negedge clk);
         o = obs();
         total++;
         if (o !== exp_q[0]) begin
            bad++;
            $display("FAIL async_pre cyc=%0d got=%b exp=%b", c, o, exp_q[0]);
         end
         void'(exp_q.pop_front());
         if (c != 6) begin
            @(posedge clk); #1;
         end
      end
      stim_q.delete();
      exp_q.delete();
      {start_rst, start_flush, stall, wb_needed, wb_ack} = 5'b00000;
      #2 rst = 1'b0;
      #1;
      o = obs();
      total++;
      if (o !== 9'd0) begin
         bad++;
         $display("FAIL async_immediate got=%b exp=%b", o, 9'd0);
      end
      @(posedge clk); #1;
      o = obs();
      total++;
      if (o !== 9'd0) begin
         bad++;
         $display("FAIL async_held got=%b exp=%b", o, 9'd0);
      end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      idle_set = 2'd0;
      for (int k = 0; k < 3; k++) begin
         stim_q.push_back(5'b00000);
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      end
      push_sweep(1'b0, 1'b1, -1, -1, 0, 1'b0, 1'b0);
      c = 0;
      while (stim_q.size() > 0) begin
         {start_rst, start_flush, stall, wb_needed, wb_ack} = stim_q.pop_front();
         @(negedge clk);
         o = obs();
         total++;
         if (o !== exp_q[0]) begin
            bad++;
            $display("FAIL async_post cyc=%0d got=%b exp=%b", c, o, exp_q[0]);
         end
         void'(exp_q.pop_front());
         c++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] o;
      int c;
      push_sweep(1'b1, 1'b0, -1, 2, 2, 1'b0, 1'b1);
      push_sweep(1'b0, 1'b1, 0, -1, 0, 1'b0, 1'b1);
      push_sweep(1'b0, 1'b1, 3, -1, 0, 1'b0, 1'b0);
      c = 0;
      while (stim_q.size() > 0) begin
         {start_rst, start_flush, stall, wb_needed, wb_ack} = stim_q.pop_front();
         @(negedge clk);
         o = obs();
         total++;
         if (o !== exp_q[0]) begin
            bad++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, o, exp_q[0]);
         end
         void'(exp_q.pop_front());
         c++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_rst_sweep();
      test_flush_wb();
      test_both_start();
      test_stall();
      test_async_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
